// File: rtl/seg_scan_capture.sv
// ----------------------------------------------------------------------------
// seg_scan_capture
//   Receive-side counterpart of a hex-to-7-segment scan driver. Snoops the
//   multiplexed segment bus and the active-low digit select, waits for the bus
//   to stay unchanged for STABLE_CYCLES samples, then decodes the settled
//   pattern back into a 4-bit hex value and dp bit for the selected digit.
//
//   Decode table, gfedcba -> hex:
//   0111111=0 0000110=1 1011011=2 1001111=3 1100110=4 1101101=5 1111101=6 0000111=7
//   1111111=8 1101111=9 1110111=A 1111100=B 0111001=C 1011110=D 1111001=E 1110001=F
//
// Ports
//   clk       system clock (inputs assumed synchronous to it)
//   rst       asynchronous active-high reset
//   seg_in    {g,f,e,d,c,b,a,dp}, active-high segments
//   ds        digit select, active-low one-hot; ds[i]=0 selects digit i
//   clr       synchronous clear of valid (captured data retained)
//   digits    recovered hex, digit i at [4i+3:4i]
//   dp_flags  recovered dp bit per digit
//   valid     digit i captured since reset/clr
//   upd       1-cycle pulse on capture, upd_idx = captured digit
//   err       1-cycle pulse on undecodable settled bus, err_code = reason
//             (1 = multiple digits selected, 2 = blank segments, 3 = unknown)
// ----------------------------------------------------------------------------
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [7:0]  ds,
    input  logic        clr,
    output logic [31:0] digits,
    output logic [7:0]  dp_flags,
    output logic [7:0]  valid,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      seg_q;
    logic [7:0]      ds_q;
    logic [7:0][3:0] digits_q, digits_d;
    logic [7:0]      dp_q, dp_d;
    logic [7:0]      valid_q, valid_d;
    logic            upd_q, upd_d;
    logic [2:0]      upd_idx_q, upd_idx_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            chg;
    logic [3:0]      nz;
    logic [2:0]      sel_idx;
    logic [4:0]      dec;

    // Returns {known, hex} for a gfedcba pattern.
    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'b0111111: dec7 = {1'b1, 4'h0};
            7'b0000110: dec7 = {1'b1, 4'h1};
            7'b1011011: dec7 = {1'b1, 4'h2};
            7'b1001111: dec7 = {1'b1, 4'h3};
            7'b1100110: dec7 = {1'b1, 4'h4};
            7'b1101101: dec7 = {1'b1, 4'h5};
            7'b1111101: dec7 = {1'b1, 4'h6};
            7'b0000111: dec7 = {1'b1, 4'h7};
            7'b1111111: dec7 = {1'b1, 4'h8};
            7'b1101111: dec7 = {1'b1, 4'h9};
            7'b1110111: dec7 = {1'b1, 4'hA};
            7'b1111100: dec7 = {1'b1, 4'hB};
            7'b0111001: dec7 = {1'b1, 4'hC};
            7'b1011110: dec7 = {1'b1, 4'hD};
            7'b1111001: dec7 = {1'b1, 4'hE};
            7'b1110001: dec7 = {1'b1, 4'hF};
            default:    dec7 = 5'b0;
        endcase
    endfunction

    assign chg = (seg_in != seg_q) | (ds != ds_q);
    assign dec = dec7(seg_q[7:1]);

    // Number of selected (low) digit lines and index of the selected one.
    always_comb begin
        nz      = 4'd0;
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!ds_q[i]) begin
                nz      = nz + 4'd1;
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        valid_d    = clr ? 8'h00 : valid_q;
        upd_d      = 1'b0;
        upd_idx_d  = upd_idx_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            SETTLE: begin
                if (chg) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Bus has been stable long enough; seg_q/ds_q equal the inputs.
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (ds_q == 8'hFF) begin
                        // display blanked: nothing to capture
                    end else if (nz > 4'd1) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else if (seg_q[7:1] == 7'b0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end else if (!dec[4]) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd3;
                    end else begin
                        digits_d[sel_idx] = dec[3:0];
                        dp_d[sel_idx]     = seg_q[0];
                        valid_d[sel_idx]  = 1'b1;
                        upd_d             = 1'b1;
                        upd_idx_d         = sel_idx;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (chg) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SETTLE;
            cnt_q      <= '0;
            seg_q      <= 8'h00;
            ds_q       <= 8'hFF;
            digits_q   <= '0;
            dp_q       <= 8'h00;
            valid_q    <= 8'h00;
            upd_q      <= 1'b0;
            upd_idx_q  <= 3'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_in;
            ds_q       <= ds;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            upd_idx_q  <= upd_idx_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign digits   = digits_q;
    assign dp_flags = dp_q;
    assign valid    = valid_q;
    assign upd      = upd_q;
    assign upd_idx  = upd_idx_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [7:0]  ds;
    logic        clr;
    logic [31:0] digits;
    logic [7:0]  dp_flags;
    logic [7:0]  valid;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    seg_scan_capture #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .ds(ds), .clr(clr),
        .digits(digits), .dp_flags(dp_flags), .valid(valid),
        .upd(upd), .upd_idx(upd_idx), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (upd) upd_cnt++;
        if (err) err_cnt++;
    end

    function automatic logic [7:0] enc(input int h, input logic dp);
        logic [6:0] s;
        case (h)
            0:  s = 7'b0111111;  1:  s = 7'b0000110;
            2:  s = 7'b1011011;  3:  s = 7'b1001111;
            4:  s = 7'b1100110;  5:  s = 7'b1101101;
            6:  s = 7'b1111101;  7:  s = 7'b0000111;
            8:  s = 7'b1111111;  9:  s = 7'b1101111;
            10: s = 7'b1110111;  11: s = 7'b1111100;
            12: s = 7'b0111001;  13: s = 7'b1011110;
            14: s = 7'b1111001;  default: s = 7'b1110001;
        endcase
        return {s, dp};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; seg_in = 8'h00; ds = 8'hFF; clr = 1'b0;
        tick(2);
        checks++;
        if ({digits, dp_flags, valid, upd, upd_idx, err, err_code} !== 55'd0) begin
            errors++;
            $display("FAIL reset_outputs got digits=%h dp=%h valid=%h upd=%b idx=%0d err=%b code=%0d want all 0",
                     digits, dp_flags, valid, upd, upd_idx, err, err_code);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_capture;
        upd_cnt = 0;
        seg_in = 8'h7E; ds = 8'h7F;
        tick(S);
        checks++;
        if (upd !== 1'b0) begin
            errors++; $display("FAIL first_early_upd got %b want 0", upd);
        end
        tick(1);
        checks++;
        if (upd !== 1'b1 || upd_idx !== 3'd7) begin
            errors++; $display("FAIL first_latency got upd=%b idx=%0d want 1/7", upd, upd_idx);
        end
        tick(10 - S - 1);
        checks++;
        if (upd_cnt != 1 || digits[31:28] !== 4'h0 || valid !== 8'h80 || dp_flags !== 8'h00) begin
            errors++;
            $display("FAIL first_result got upds=%0d d7=%h valid=%h dp=%h want 1/0/80/00",
                     upd_cnt, digits[31:28], valid, dp_flags);
        end
    endtask

    task automatic test_scan;
        upd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            ds = ~(8'h01 << i);
            seg_in = enc(i, i == 3);
            tick(6);
        end
        checks++;
        if (digits !== 32'h76543210 || dp_flags !== 8'h08 || valid !== 8'hFF || upd_cnt != 8) begin
            errors++;
            $display("FAIL scan got digits=%h dp=%h valid=%h upds=%0d want 76543210/08/FF/8",
                     digits, dp_flags, valid, upd_cnt);
        end
    endtask

    task automatic test_debounce;
        int early;
        upd_cnt = 0;
        ds = 8'hFE;
        for (int k = 0; k < 10; k++) begin
            seg_in = enc((k % 2) ? 2 : 1, 1'b0);
            tick(2);
        end
        checks++;
        if (upd_cnt != 0) begin
            errors++; $display("FAIL debounce_toggle got upds=%0d want 0", upd_cnt);
        end
        seg_in = enc(15, 1'b0);
        early = 0;
        for (int k = 0; k < S; k++) begin
            tick(1);
            if (upd) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL debounce_early got %0d pulses want 0", early);
        end
        tick(1);
        checks++;
        if (upd !== 1'b1 || digits[3:0] !== 4'hF) begin
            errors++; $display("FAIL debounce_capture got upd=%b d0=%h want 1/F", upd, digits[3:0]);
        end
        tick(3);
        checks++;
        if (upd_cnt != 1) begin
            errors++; $display("FAIL debounce_single got upds=%0d want 1", upd_cnt);
        end
    endtask

    task automatic test_errors;
        upd_cnt = 0; err_cnt = 0;
        ds = 8'h3F; seg_in = enc(5, 1'b0);
        tick(6);
        checks++;
        if (err_cnt != 1 || err_code !== 2'd1) begin
            errors++; $display("FAIL err_multi got errs=%0d code=%0d want 1/1", err_cnt, err_code);
        end
        ds = 8'hFE; seg_in = 8'h00;
        tick(6);
        checks++;
        if (err_cnt != 2 || err_code !== 2'd2) begin
            errors++; $display("FAIL err_blank got errs=%0d code=%0d want 2/2", err_cnt, err_code);
        end
        seg_in = 8'h02;
        tick(6);
        checks++;
        if (err_cnt != 3 || err_code !== 2'd3 || err !== 1'b0) begin
            errors++; $display("FAIL err_unknown got errs=%0d code=%0d err=%b want 3/3/0", err_cnt, err_code, err);
        end
        checks++;
        if (upd_cnt != 0 || digits !== 32'h7654321F) begin
            errors++; $display("FAIL err_nocapture got upds=%0d digits=%h want 0/7654321F", upd_cnt, digits);
        end
    endtask

    task automatic test_blank_and_clr;
        upd_cnt = 0; err_cnt = 0;
        ds = 8'hFF; seg_in = enc(3, 1'b0);
        tick(6);
        checks++;
        if (upd_cnt != 0 || err_cnt != 0) begin
            errors++; $display("FAIL blank got upds=%0d errs=%0d want 0/0", upd_cnt, err_cnt);
        end
        ds = 8'hFB; seg_in = enc(9, 1'b0);
        tick(S);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        checks++;
        if (valid !== 8'h04 || upd !== 1'b1 || upd_idx !== 3'd2 || digits[11:8] !== 4'h9) begin
            errors++;
            $display("FAIL clr_capture got valid=%h upd=%b idx=%0d d2=%h want 04/1/2/9",
                     valid, upd, upd_idx, digits[11:8]);
        end
    endtask

    task automatic test_mid_reset;
        int early;
        ds = 8'hFD; seg_in = enc(10, 1'b0);
        tick(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({digits, dp_flags, valid, upd, upd_idx, err, err_code} !== 55'd0) begin
            errors++;
            $display("FAIL async_reset got digits=%h dp=%h valid=%h code=%0d want all 0",
                     digits, dp_flags, valid, err_code);
        end
        tick(2);
        rst = 1'b0;
        early = 0;
        for (int k = 0; k < S; k++) begin
            tick(1);
            if (upd) early++;
        end
        tick(1);
        checks++;
        if (early != 0 || upd !== 1'b1 || digits !== 32'h000000A0 || valid !== 8'h02) begin
            errors++;
            $display("FAIL recapture got early=%0d upd=%b digits=%h valid=%h want 0/1/000000A0/02",
                     early, upd, digits, valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_scan();
        test_debounce();
        test_errors();
        test_blank_and_clr();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
